alut_wb_buf: RTL and testbench

ALUT_WB_BUF -- requirements
Module: alut_wb_buf

---
 rtl/alut_wb_buf.sv | 143 ++++++++++++++
 tb/tb_alut_wb_buf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alut_wb_buf.sv
// ---------------------------------------------------------------------------
// alut_wb_buf
//   Small in-order queue between the execute lane and register writeback.
//   Finished execute results are pushed at the tail and presented to
//   writeback from the head, straight out of the storage registers.
//   Results still owned by a multi-cycle mul/div (ex_busy_i) are held off
//   until their final value appears.
//
// Parameters
//   DEPTH          queue entries, 2 or 4
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   ex_valid_i     execute presents a result this cycle
//   ex_busy_i      result not final yet (multi-cycle op in flight)
//   ex_rd_ena_i    result writes a register
//   ex_rd_addr_i   destination register
//   ex_rd_data_i   result data
//   ex_pc_i        instruction PC
//   ex_inst_i      instruction word
//   flush_i        drop every queued and presented result
//   wb_ready_i     writeback takes the head entry this cycle
//   ex_ready_o     queue can take a push this cycle
//   wb_valid_o     head entry present
//   wb_rd_ena_o    head entry fields (all zero while the queue is empty)
//   wb_rd_addr_o
//   wb_rd_data_o
//   wb_pc_o
//   wb_inst_o
//   retire_cnt_o   running count of entries handed to writeback
// ---------------------------------------------------------------------------
module alut_wb_buf #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        ex_busy_i,
    input  logic        ex_rd_ena_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [63:0] ex_rd_data_i,
    input  logic [63:0] ex_pc_i,
    input  logic [31:0] ex_inst_i,
    input  logic        flush_i,
    input  logic        wb_ready_i,
    output logic        ex_ready_o,
    output logic        wb_valid_o,
    output logic        wb_rd_ena_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [63:0] wb_rd_data_o,
    output logic [63:0] wb_pc_o,
    output logic [31:0] wb_inst_o,
    output logic [63:0] retire_cnt_o
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      retire_cnt_q, retire_cnt_d;

    // Payload storage; never reset, every read is masked by the count.
    logic        rd_ena_mem  [DEPTH];
    logic [4:0]  rd_addr_mem [DEPTH];
    logic [63:0] rd_data_mem [DEPTH];
    logic [63:0] pc_mem      [DEPTH];
    logic [31:0] inst_mem    [DEPTH];

    logic push;
    logic pop;

    // Ready looks only at the registered count: a full queue refuses the
    // push even when writeback is draining the head in the same cycle.
    assign ex_ready_o = (count_q != CNT_W'(DEPTH));
    assign wb_valid_o = (count_q != '0);

    assign push = ex_valid_i & ~ex_busy_i & ex_ready_o & ~flush_i;
    assign pop  = wb_valid_o & wb_ready_i & ~flush_i;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        retire_cnt_d = retire_cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + PTR_W'(1);
                retire_cnt_d = retire_cnt_q + 64'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Writes to x0 are architecturally dead, so the enable is dropped here
    // and writeback never has to special-case register zero.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_ena_mem[wr_ptr_q]  <= ex_rd_ena_i & (ex_rd_addr_i != 5'd0);
            rd_addr_mem[wr_ptr_q] <= ex_rd_addr_i;
            rd_data_mem[wr_ptr_q] <= ex_rd_data_i;
            pc_mem[wr_ptr_q]      <= ex_pc_i;
            inst_mem[wr_ptr_q]    <= ex_inst_i;
        end
    end

    assign wb_rd_ena_o  = wb_valid_o ? rd_ena_mem[rd_ptr_q]  : 1'b0;
    assign wb_rd_addr_o = wb_valid_o ? rd_addr_mem[rd_ptr_q] : 5'd0;
    assign wb_rd_data_o = wb_valid_o ? rd_data_mem[rd_ptr_q] : 64'd0;
    assign wb_pc_o      = wb_valid_o ? pc_mem[rd_ptr_q]      : 64'd0;
    assign wb_inst_o    = wb_valid_o ? inst_mem[rd_ptr_q]    : 32'd0;

    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_alut_wb_buf.sv
// ---------------------------------------------------------------------------
// tb_alut_wb_buf
//   Directed bench for alut_wb_buf (DEPTH=2). Accepted pushes go into a
//   scoreboard queue; each cycle the head of the queue is compared with the
//   writeback outputs and popped when writeback takes it.
// ---------------------------------------------------------------------------
module tb_alut_wb_buf;

    localparam int DEPTH = 2;

    typedef struct {
        logic        ena;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [63:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, ex_busy_i, ex_rd_ena_i;
    logic [4:0]  ex_rd_addr_i;
    logic [63:0] ex_rd_data_i, ex_pc_i;
    logic [31:0] ex_inst_i;
    logic        flush_i, wb_ready_i;
    logic        ex_ready_o, wb_valid_o, wb_rd_ena_o;
    logic [4:0]  wb_rd_addr_o;
    logic [63:0] wb_rd_data_o, wb_pc_o;
    logic [31:0] wb_inst_o;
    logic [63:0] retire_cnt_o;

    entry_t      sb_q[$];
    logic [63:0] exp_retire;
    int          checks = 0;
    int          errors = 0;

    alut_wb_buf #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid_i   (ex_valid_i),
        .ex_busy_i    (ex_busy_i),
        .ex_rd_ena_i  (ex_rd_ena_i),
        .ex_rd_addr_i (ex_rd_addr_i),
        .ex_rd_data_i (ex_rd_data_i),
        .ex_pc_i      (ex_pc_i),
        .ex_inst_i    (ex_inst_i),
        .flush_i      (flush_i),
        .wb_ready_i   (wb_ready_i),
        .ex_ready_o   (ex_ready_o),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_ena_o  (wb_rd_ena_o),
        .wb_rd_addr_o (wb_rd_addr_o),
        .wb_rd_data_o (wb_rd_data_o),
        .wb_pc_o      (wb_pc_o),
        .wb_inst_o    (wb_inst_o),
        .retire_cnt_o (retire_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with the scoreboard's view of the queue.
    task automatic check_state(input string step);
        entry_t e;
        check({step, ":wb_valid"}, 64'(wb_valid_o), 64'(sb_q.size() != 0));
        check({step, ":ex_ready"}, 64'(ex_ready_o), 64'(sb_q.size() != DEPTH));
        check({step, ":retire"}, retire_cnt_o, exp_retire);
        if (sb_q.size() != 0) begin
            e = sb_q[0];
        end else begin
            e = '{ena: 1'b0, addr: 5'd0, data: 64'd0, pc: 64'd0, inst: 32'd0};
        end
        check({step, ":rd_ena"},  64'(wb_rd_ena_o),  64'(e.ena));
        check({step, ":rd_addr"}, 64'(wb_rd_addr_o), 64'(e.addr));
        check({step, ":rd_data"}, wb_rd_data_o,      e.data);
        check({step, ":pc"},      wb_pc_o,           e.pc);
        check({step, ":inst"},    64'(wb_inst_o),    64'(e.inst));
    endtask

    // Check current outputs, clock once with the inputs as driven, then
    // advance the scoreboard by what the DUT should have done at the edge.
    task automatic cycle(input string step);
        logic   do_push, do_pop;
        entry_t e;
        check_state(step);
        do_push = ex_valid_i && !ex_busy_i && (sb_q.size() != DEPTH) && !flush_i;
        do_pop  = (sb_q.size() != 0) && wb_ready_i && !flush_i;
        e = '{ena: ex_rd_ena_i && (ex_rd_addr_i != 5'd0), addr: ex_rd_addr_i,
              data: ex_rd_data_i, pc: ex_pc_i, inst: ex_inst_i};
        @(posedge clk);
        #1;
        if (flush_i) begin
            sb_q.delete();
        end else begin
            if (do_pop) begin
                void'(sb_q.pop_front());
                exp_retire++;
            end
            if (do_push) sb_q.push_back(e);
        end
        $display("step %-12s push=%0d pop=%0d flush=%0d depth=%0d retire=%0d",
                 step, do_push, do_pop, flush_i, sb_q.size(), exp_retire);
    endtask

    task automatic drive(input logic valid, input logic busy, input logic ena,
                         input logic [4:0] addr, input logic [63:0] data,
                         input logic [63:0] pc, input logic [31:0] inst,
                         input logic flush, input logic ready);
        ex_valid_i   = valid;
        ex_busy_i    = busy;
        ex_rd_ena_i  = ena;
        ex_rd_addr_i = addr;
        ex_rd_data_i = data;
        ex_pc_i      = pc;
        ex_inst_i    = inst;
        flush_i      = flush;
        wb_ready_i   = ready;
    endtask

    initial begin
        exp_retire = 64'd0;
        rst = 1'b1;
        drive(0, 0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 0, 0);
        #2 rst = 1'b0;
        #4 check_state("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Single push, held while writeback stalls, then retired.
        drive(1, 0, 1, 5'd5, 64'h1234, 64'h8000_0000, 32'h0000_0013, 0, 0);
        cycle("push1");
        drive(0, 0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 0, 0);
        cycle("hold1");
        cycle("hold2");
        wb_ready_i = 1'b1;
        cycle("pop1");
        check_state("after_pop1");

        // Fill to DEPTH with writeback stalled; the third push is refused.
        drive(1, 0, 1, 5'd1, 64'hA, 64'h100, 32'hAAAA_0001, 0, 0);
        cycle("push_A");
        drive(1, 0, 1, 5'd2, 64'hB, 64'h104, 32'hBBBB_0002, 0, 0);
        cycle("push_B");
        drive(1, 0, 1, 5'd3, 64'hC, 64'h108, 32'hCCCC_0003, 0, 0);
        cycle("push_C");
        drive(0, 0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 0, 1);
        cycle("drain_A");
        cycle("drain_B");
        cycle("drain_idle");

        // Busy result held for ten cycles; only the final value is queued.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 5'd7, 64'(i), 64'h200, 32'h0200_0033, 0, 0);
            cycle("busy");
        end
        drive(1, 0, 1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h200, 32'h0200_0033, 0, 0);
        cycle("busy_done");
        drive(0, 0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 0, 0);
        cycle("busy_hold");
        wb_ready_i = 1'b1;
        cycle("busy_pop");

        // Flush a full queue while a push and a pop are also requested.
        drive(1, 0, 1, 5'd8, 64'h11, 64'h300, 32'h1, 0, 0);
        cycle("fill1");
        drive(1, 0, 1, 5'd9, 64'h22, 64'h304, 32'h2, 0, 0);
        cycle("fill2");
        drive(1, 0, 1, 5'd10, 64'h33, 64'h308, 32'h3, 1, 1);
        cycle("flush");
        drive(0, 0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 0, 0);
        cycle("post_flush");

        // Push and pop together at count 1: new entry becomes head.
        drive(1, 0, 1, 5'd11, 64'h44, 64'h400, 32'h4, 0, 0);
        cycle("pp_fill");
        drive(1, 0, 1, 5'd12, 64'h55, 64'h404, 32'h5, 0, 1);
        cycle("pp_both");
        drive(0, 0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 0, 0);
        cycle("pp_check");

        // Register zero destination: enable suppressed at the output.
        drive(1, 0, 1, 5'd0, 64'h66, 64'h500, 32'h6, 0, 0);
        cycle("x0_push");
        drive(0, 0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 0, 0);
        cycle("x0_hold");

        // Asynchronous reset in the middle of a cycle with one entry queued.
        #2 rst = 1'b0;
        sb_q.delete();
        exp_retire = 64'd0;
        #1 check_state("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 1, 5'd13, 64'h77, 64'h600, 32'h7, 0, 0);
        cycle("rst_push");

        // Mixed random traffic.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom,
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            cycle("random");
        end
        drive(0, 0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 0, 1);
        cycle("final_drain");
        cycle("final_drain");
        cycle("final_drain");
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
